// File: rtl/hex_display_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : hex_disp_pkg
//  Purpose : Shared types and constants for the hex display arbiter: FSM state
//            encoding, default dwell/flash timing, the all-segments-off pattern
//            and an index-width helper.
//  Config  : HEX_FLASH_EN (consumed by hex_display_arbiter, not here)
//  Revision: 1.0 - initial release
// ============================================================================
package hex_disp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // 0.5 s and 50 ms at a 50 MHz board clock
    localparam int c_dwell_cycles_default = 25_000_000;
    localparam int c_flash_cycles_default = 2_500_000;

    // Segment pattern the downstream decoder drives while disp_blank is high
    localparam logic [6:0] c_blank_seg = 7'b1111111;

    // Width of a counter/index that must hold values 0..n-1, never below 1 bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : hex_disp_pkg
`default_nettype wire

// File: rtl/hex_display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : hex_display_arbiter_if
//  Purpose : Bundles the requester side (req / req_value) and the display side
//            (grant, disp_value, disp_src, disp_blank, switch_pulse) of the
//            hex display arbiter.
//  Ports   : master modport - requesters/testbench: drive req, req_value;
//                             observe the display outputs.
//            slave modport  - arbiter: observes req, req_value; drives the
//                             display outputs.
//  Revision: 1.0 - initial release
// ============================================================================
interface hex_display_arbiter_if
    import hex_disp_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    localparam int c_idx_w = idx_w(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_value;
    logic [N_REQ-1:0]   grant;
    logic [7:0]         disp_value;
    logic [c_idx_w-1:0] disp_src;
    logic               disp_blank;
    logic               switch_pulse;

    modport master (
        output req,
        output req_value,
        input  grant,
        input  disp_value,
        input  disp_src,
        input  disp_blank,
        input  switch_pulse
    );

    modport slave (
        input  req,
        input  req_value,
        output grant,
        output disp_value,
        output disp_src,
        output disp_blank,
        output switch_pulse
    );

endinterface : hex_display_arbiter_if
`default_nettype wire

// File: rtl/hex_display_arbiter_picker.sv
`default_nettype none
// ============================================================================
//  Module  : hex_rr_picker
//  Purpose : Combinational round-robin search. Scans indices ptr+1, ptr+2, ...
//            (mod N_REQ) and reports the first asserted request. Two results:
//            one over all N_REQ positions (ptr itself checked last) and one
//            that skips ptr entirely, used when the owner must not re-win.
//  Ports   : i_req         request vector
//            i_ptr         last granted index
//            o_win_idx     winner over all positions
//            o_win_any     any request asserted
//            o_win_ex_idx  winner with index ptr excluded
//            o_win_ex_any  any request other than ptr asserted
//  Revision: 1.0 - initial release
// ============================================================================
module hex_rr_picker
    import hex_disp_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [IDX_W-1:0] o_win_idx,
    output logic                  o_win_any,
    output logic      [IDX_W-1:0] o_win_ex_idx,
    output logic                  o_win_ex_any
);

    int w_idx;

    // Walk from the farthest offset to the nearest so the nearest asserted
    // request is the last assignment and therefore the winner.
    always_comb begin
        o_win_idx    = '0;
        o_win_any    = 1'b0;
        o_win_ex_idx = '0;
        o_win_ex_any = 1'b0;
        w_idx        = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (i_req[IDX_W'(w_idx)]) begin
                o_win_idx = IDX_W'(w_idx);
                o_win_any = 1'b1;
                // Offset N_REQ lands back on ptr: that is the owner itself
                if (k != N_REQ) begin
                    o_win_ex_idx = IDX_W'(w_idx);
                    o_win_ex_any = 1'b1;
                end
            end
        end
    end

endmodule : hex_rr_picker
`default_nettype wire

// File: rtl/hex_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : hex_display_arbiter
//  Purpose : Shares one two-digit hex display among N_REQ requesters using
//            round-robin arbitration with a minimum dwell time per grant.
//            Feeds value/blank to the existing nibble-to-segment decoder.
//  Ports   : clk    clock
//            rst_n  asynchronous reset, active low
//            bus    hex_display_arbiter_if.slave
//                     req, req_value           (in)
//                     grant, disp_value, disp_src,
//                     disp_blank, switch_pulse (out, all registered)
//  Config  : HEX_FLASH_EN - when defined, blank the display for FLASH_CYCLES
//            cycles after every source change; otherwise blank only in IDLE.
//  Revision: 1.0 - initial release
// ============================================================================
module hex_display_arbiter
    import hex_disp_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = c_dwell_cycles_default,
    parameter int FLASH_CYCLES = c_flash_cycles_default
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    hex_display_arbiter_if.slave bus
);

    localparam int c_idx_w = idx_w(N_REQ);
    localparam int c_dw_w  = idx_w(DWELL_CYCLES);

    localparam logic [c_dw_w-1:0]  c_dwell_load = c_dw_w'(DWELL_CYCLES - 1);
    localparam logic [c_dw_w-1:0]  c_dwell_one  = c_dw_w'(1);
    localparam logic [c_idx_w-1:0] c_ptr_reset  = c_idx_w'(N_REQ - 1);
    localparam logic [N_REQ-1:0]   c_grant_one  = N_REQ'(1);

    if (N_REQ < 2 || N_REQ > 8 || DWELL_CYCLES < 2 || FLASH_CYCLES < 1) begin : g_param_check
        $error("hex_display_arbiter: parameter out of range");
    end

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [7:0]         r_value;
    logic [c_idx_w-1:0] r_src;
    logic [c_idx_w-1:0] r_ptr;
    logic               r_blank;
    logic               r_pulse;
    logic [c_dw_w-1:0]  r_dwell;

    state_t             w_state_nxt;
    logic [N_REQ-1:0]   w_grant_nxt;
    logic [7:0]         w_value_nxt;
    logic [c_idx_w-1:0] w_src_nxt;
    logic [c_idx_w-1:0] w_ptr_nxt;
    logic               w_blank_nxt;
    logic               w_pulse_nxt;
    logic [c_dw_w-1:0]  w_dwell_nxt;
    logic               w_take;
    logic [c_idx_w-1:0] w_take_idx;

`ifdef HEX_FLASH_EN
    localparam int c_fl_w = idx_w(FLASH_CYCLES);
    localparam logic [c_fl_w-1:0] c_flash_load = c_fl_w'(FLASH_CYCLES - 1);
    localparam logic [c_fl_w-1:0] c_flash_one  = c_fl_w'(1);

    logic [c_fl_w-1:0] r_flash;
    logic [c_fl_w-1:0] w_flash_nxt;
`endif

    // ------------------------------------------------------------------------
    // Per-requester value slices
    // ------------------------------------------------------------------------
    logic [7:0] w_vals [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_vals[i] = bus.req_value[8*i +: 8];
    end

    logic       w_owner_req;
    logic [7:0] w_owner_value;

    assign w_owner_req   = bus.req[r_src];
    assign w_owner_value = w_vals[r_src];

    // ------------------------------------------------------------------------
    // Round-robin search (ptr equals the owner while in SHOW)
    // ------------------------------------------------------------------------
    logic [c_idx_w-1:0] w_win_idx;
    logic               w_win_any;
    logic [c_idx_w-1:0] w_win_ex_idx;
    logic               w_win_ex_any;

    hex_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .i_req        (bus.req),
        .i_ptr        (r_ptr),
        .o_win_idx    (w_win_idx),
        .o_win_any    (w_win_any),
        .o_win_ex_idx (w_win_ex_idx),
        .o_win_ex_any (w_win_ex_any)
    );

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_value_nxt = r_value;
        w_src_nxt   = r_src;
        w_ptr_nxt   = r_ptr;
        w_blank_nxt = r_blank;
        w_pulse_nxt = 1'b0;
        w_dwell_nxt = r_dwell;
        w_take      = 1'b0;
        w_take_idx  = w_win_idx;

        case (r_state)
            IDLE: begin
                w_blank_nxt = 1'b1;
                if (w_win_any) begin
                    w_take     = 1'b1;
                    w_take_idx = w_win_idx;
                end
            end
            SHOW: begin
                w_blank_nxt = 1'b0;
                if (r_dwell != '0) begin
                    // Still inside the dwell window: grant is locked, value
                    // follows the owner only while it keeps requesting.
                    w_dwell_nxt = r_dwell - c_dwell_one;
                    if (w_owner_req) begin
                        w_value_nxt = w_owner_value;
                    end
                end else if (w_win_ex_any) begin
                    w_take     = 1'b1;
                    w_take_idx = w_win_ex_idx;
                end else if (w_owner_req) begin
                    // Sole requester keeps the display; counter parks at 0 so
                    // any newcomer is taken on the very next evaluation.
                    w_value_nxt = w_owner_value;
                end else begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_blank_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_blank_nxt = 1'b1;
            end
        endcase

        if (w_take) begin
            w_state_nxt = SHOW;
            w_grant_nxt = c_grant_one << w_take_idx;
            w_src_nxt   = w_take_idx;
            w_ptr_nxt   = w_take_idx;
            w_value_nxt = w_vals[w_take_idx];
            w_blank_nxt = 1'b0;
            w_pulse_nxt = 1'b1;
            w_dwell_nxt = c_dwell_load;
        end

`ifdef HEX_FLASH_EN
        // Flash timer runs alongside the dwell counter and never extends it
        w_flash_nxt = (r_flash != '0) ? (r_flash - c_flash_one) : r_flash;
        if (w_take) begin
            w_flash_nxt = c_flash_load;
            w_blank_nxt = 1'b1;
        end else if (w_state_nxt == SHOW) begin
            w_blank_nxt = (r_flash != '0);
        end
`endif
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_value <= 8'h00;
            r_src   <= '0;
            r_ptr   <= c_ptr_reset;
            r_blank <= 1'b1;
            r_pulse <= 1'b0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_value <= w_value_nxt;
            r_src   <= w_src_nxt;
            r_ptr   <= w_ptr_nxt;
            r_blank <= w_blank_nxt;
            r_pulse <= w_pulse_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

`ifdef HEX_FLASH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flash <= '0;
        end else begin
            r_flash <= w_flash_nxt;
        end
    end
`endif

    assign bus.grant        = r_grant;
    assign bus.disp_value   = r_value;
    assign bus.disp_src     = r_src;
    assign bus.disp_blank   = r_blank;
    assign bus.switch_pulse = r_pulse;

endmodule : hex_display_arbiter
`default_nettype wire
